seg_digit_receiver: RTL

SEG_DIGIT_RECEIVER -- requirements
Module: seg_digit_receiver

---
 rtl/seg_digit_receiver.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/seg_digit_receiver.sv
// Receives two 7-segment patterns: tens first, then units.
// It decodes them to a binary value (tens*10+units).
// A result above MAX_VALUE is flagged as an error.
// An illegal pattern is flagged as an error.
// A units digit that does not arrive within TIMEOUT cycles is flagged as an error.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   seg_in       pattern {g,f,e,d,c,b,a}, active-high segments
//   seg_valid    seg_in holds a pattern
//   seg_ready    block accepts a pattern this cycle
//   value        last valid result
//   value_valid  one-cycle pulse, new result on value
//   err          one-cycle pulse, transaction aborted
//   err_code     00 none, 01 illegal, 10 timeout, 11 out of range
//   busy         transaction in progress (WAIT_UNITS or RESULT)
module seg_digit_receiver #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_VALUE = 81
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       seg_valid,
    output logic       seg_ready,
    output logic [6:0] value,
    output logic       value_valid,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_RANGE   = 2'b11;

    typedef enum logic [1:0] {
        WAIT_TENS  = 2'd0,
        WAIT_UNITS = 2'd1,
        RESULT     = 2'd2
    } state_t;

    state_t           state_q;
    logic [3:0]       tens_q;
    logic [CNT_W-1:0] cnt_q;
    logic [6:0]       value_q;
    logic             value_valid_q;
    logic             err_q;
    logic [1:0]       err_code_q;
    logic             seg_ready_q;
    logic             busy_q;

    logic             accept;
    logic [4:0]       tens_dec;
    logic [4:0]       units_dec;
    logic [6:0]       sum;

    // Pattern decoder; returns {legal, digit}. Blank is legal only as a tens digit.
    function automatic logic [4:0] decode(input logic [6:0] pat, input logic allow_blank);
        logic [4:0] res;
        res = 5'b0_0000;
        case (pat)
            7'b0111111: res = 5'b1_0000;
            7'b0000110: res = 5'b1_0001;
            7'b1011011: res = 5'b1_0010;
            7'b1001111: res = 5'b1_0011;
            7'b1100110: res = 5'b1_0100;
            7'b1101101: res = 5'b1_0101;
            7'b1111101: res = 5'b1_0110;
            7'b0000111: res = 5'b1_0111;
            7'b1111111: res = 5'b1_1000;
            7'b1101111: res = 5'b1_1001;
            7'b0000000: res = allow_blank ? 5'b1_0000 : 5'b0_0000;
            default:    res = 5'b0_0000;
        endcase
        return res;
    endfunction

    // Handshake and datapath helpers.
    always_comb begin
        accept    = seg_valid && seg_ready_q;
        tens_dec  = decode(seg_in, 1'b1);
        units_dec = decode(seg_in, 1'b0);
        // Maximum 9*10+9 = 99, fits in 7 bits.
        sum       = 7'(tens_q) * 7'd10 + 7'(units_dec[3:0]);
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_TENS;
            tens_q        <= 4'd0;
            cnt_q         <= '0;
            value_q       <= 7'd0;
            value_valid_q <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= 2'b00;
            seg_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            value_valid_q <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= 2'b00;
            case (state_q)
                WAIT_TENS: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (tens_dec[4]) begin
                            tens_q  <= tens_dec[3:0];
                            cnt_q   <= '0;
                            state_q <= WAIT_UNITS;
                        end else begin
                            state_q     <= RESULT;
                            seg_ready_q <= 1'b0;
                            err_q       <= 1'b1;
                            err_code_q  <= ERR_ILLEGAL;
                        end
                    end
                end
                WAIT_UNITS: begin
                    // Acceptance takes priority over an expiring timeout.
                    if (accept) begin
                        state_q     <= RESULT;
                        seg_ready_q <= 1'b0;
                        if (!units_dec[4]) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_ILLEGAL;
                        end else if (sum > 7'(MAX_VALUE)) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_RANGE;
                        end else begin
                            value_q       <= sum;
                            value_valid_q <= 1'b1;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q     <= RESULT;
                        seg_ready_q <= 1'b0;
                        err_q       <= 1'b1;
                        err_code_q  <= ERR_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESULT: begin
                    state_q     <= WAIT_TENS;
                    seg_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= WAIT_TENS;
                    seg_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign seg_ready   = seg_ready_q;
    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign busy        = busy_q;

endmodule
